// File: rtl/signed_step_counter.sv
// Three debounced pushbuttons drive a saturating 4-bit signed counter (-8..+7) for the display stage.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on the up/down buttons.
module signed_step_counter #(
    parameter logic [31:0] DB_CNT     = 32'd1000000,
    parameter logic [31:0] RPT_DELAY  = 32'd50000000,
    parameter logic [31:0] RPT_PERIOD = 32'd20000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              btn_clr,
    output logic signed [3:0] digit,
    output logic              sat
);

    localparam int UP  = 0;
    localparam int DN  = 1;
    localparam int CLR = 2;

    logic [2:0]        w_raw;
    logic [2:0]        r_s1;
    logic [2:0]        r_s2;
    logic [2:0]        r_db;
    logic [2:0]        r_db_q;
    logic [31:0]       r_cnt [3];
    logic [2:0]        w_press;
    logic              w_rpt_up;
    logic              w_rpt_dn;
    logic              w_step_up;
    logic              w_step_dn;
    logic              w_clr;
    logic signed [3:0] w_digit_nxt;
    logic              w_sat_nxt;

    // A step in the requested direction would leave the -8..+7 range.
    function automatic logic f_at_limit(input logic signed [3:0] v, input logic up);
        return up ? (v == 4'sb0111) : (v == 4'sb1000);
    endfunction

    assign w_raw = {btn_clr, btn_dn, btn_up};

    // Stage 0: synchronise, debounce and remember the previous debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_db   <= '0;
            r_db_q <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_s1   <= w_raw;
            r_s2   <= r_s1;
            r_db_q <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] != r_db[i]) begin
                    if (r_cnt[i] == DB_CNT - 32'd1) begin
                        r_db[i]  <= r_s2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 32'd1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_press = r_db & ~r_db_q;

`ifdef AUTO_REPEAT_EN
    logic        w_hold;
    logic        w_rpt;
    logic        r_rpt_armed;
    logic [31:0] r_rpt_cnt;

    // Exactly one of up/down held; the first repeat waits RPT_DELAY, later ones RPT_PERIOD.
    assign w_hold = r_db[UP] ^ r_db[DN];
    assign w_rpt  = w_hold &&
                    (r_rpt_cnt == (r_rpt_armed ? RPT_PERIOD - 32'd1 : RPT_DELAY - 32'd1));

    always_ff @(posedge clk) begin
        if (rst || !w_hold || w_press[CLR]) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b0;
        end else if (w_rpt) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b1;
        end else begin
            r_rpt_cnt   <= r_rpt_cnt + 32'd1;
        end
    end

    assign w_rpt_up = w_rpt & r_db[UP];
    assign w_rpt_dn = w_rpt & r_db[DN];
`else
    logic w_unused_rpt;
    assign w_unused_rpt = ^{RPT_DELAY, RPT_PERIOD};
    assign w_rpt_up     = 1'b0;
    assign w_rpt_dn     = 1'b0;
`endif

    assign w_clr     = w_press[CLR];
    assign w_step_up = w_press[UP] | w_rpt_up;
    assign w_step_dn = w_press[DN] | w_rpt_dn;

    always_comb begin
        w_digit_nxt = digit;
        w_sat_nxt   = 1'b0;
        if (w_clr) begin
            w_digit_nxt = '0;
        end else if (w_step_up && w_step_dn) begin
            w_digit_nxt = digit;
        end else if (w_step_up) begin
            if (f_at_limit(digit, 1'b1)) w_sat_nxt = 1'b1;
            else                         w_digit_nxt = digit + 4'sd1;
        end else if (w_step_dn) begin
            if (f_at_limit(digit, 1'b0)) w_sat_nxt = 1'b1;
            else                         w_digit_nxt = digit - 4'sd1;
        end
    end

    // Stage 1: registered value and saturation pulse to the display stage
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
            sat   <= 1'b0;
        end else begin
            digit <= w_digit_nxt;
            sat   <= w_sat_nxt;
        end
    end

endmodule

// File: tb/tb_signed_step_counter.sv
// Directed bench for signed_step_counter with DB_CNT=4; default build (no auto-repeat).
module tb_signed_step_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_dn;
    logic       btn_clr;
    logic [3:0] digit;
    logic       sat;
    int         vectors = 0;
    int         miscompares = 0;
    int         sat_cnt;
    int         sat_edge;

    always #5 clk = ~clk;

    signed_step_counter #(
        .DB_CNT    (32'd4),
        .RPT_DELAY (32'd20),
        .RPT_PERIOD(32'd8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .btn_clr(btn_clr),
        .digit  (digit),
        .sat    (sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the buttons in mask {clr,dn,up} for 10 edges, release for 12; report sat pulses.
    task automatic press(input logic [2:0] m, output int n_sat, output int e_sat);
        n_sat = 0;
        e_sat = 0;
        @(negedge clk);
        {btn_clr, btn_dn, btn_up} = m;
        for (int e = 1; e <= 22; e++) begin
            if (e == 11) begin
                @(negedge clk);
                {btn_clr, btn_dn, btn_up} = 3'b000;
            end
            @(posedge clk);
            #1;
            if (sat === 1'b1) begin
                n_sat++;
                e_sat = e;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        {btn_clr, btn_dn, btn_up} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_digit", {28'd0, digit}, 32'd0);
        chk("reset_sat", {31'd0, sat}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk("idle", {27'd0, digit, sat}, 32'd0);
        end

        // Latency: raw high from edge 1 -> digit 1 at edge 7, then no further step.
        @(negedge clk);
        btn_up = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            chk("latency", {27'd0, digit, sat}, (e >= 7) ? 32'd2 : 32'd0);
        end
        @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("held_once", {28'd0, digit}, 32'd1);

        press(3'b100, sat_cnt, sat_edge);
        chk("clr_from_1", {28'd0, digit}, 32'd0);

        for (int k = 1; k <= 8; k++) begin
            press(3'b001, sat_cnt, sat_edge);
            chk("up_count", {28'd0, digit}, (k <= 7) ? k : 7);
            chk("up_sat_cnt", sat_cnt, (k == 8) ? 1 : 0);
            if (k == 8) chk("up_sat_edge", sat_edge, 7);
        end

        press(3'b100, sat_cnt, sat_edge);
        chk("clr_from_7", {28'd0, digit}, 32'd0);

        for (int k = 1; k <= 9; k++) begin
            press(3'b010, sat_cnt, sat_edge);
            chk("dn_count", {28'd0, digit}, (k <= 8) ? (16 - k) : 8);
            chk("dn_sat_cnt", sat_cnt, (k == 9) ? 1 : 0);
            if (k == 9) chk("dn_sat_edge", sat_edge, 7);
        end

        press(3'b100, sat_cnt, sat_edge);
        chk("clr_from_m8", {27'd0, digit, sat}, 32'd0);

        // Three-cycle glitch stays below the debounce threshold.
        @(negedge clk);
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        btn_up = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("glitch", {27'd0, digit, sat}, 32'd0);

        press(3'b011, sat_cnt, sat_edge);
        chk("up_dn_cancel", {28'd0, digit}, 32'd0);
        chk("up_dn_sat", sat_cnt, 0);

        repeat (5) press(3'b001, sat_cnt, sat_edge);
        chk("five_up", {28'd0, digit}, 32'd5);
        press(3'b100, sat_cnt, sat_edge);
        chk("clr_from_5", {28'd0, digit}, 32'd0);

        repeat (3) press(3'b001, sat_cnt, sat_edge);
        chk("three_up", {28'd0, digit}, 32'd3);
        press(3'b101, sat_cnt, sat_edge);
        chk("clr_wins_up", {28'd0, digit}, 32'd0);
        chk("clr_wins_sat", sat_cnt, 0);

        // Reset during debounce, button released while in reset.
        press(3'b001, sat_cnt, sat_edge);
        chk("pre_rst", {28'd0, digit}, 32'd1);
        @(negedge clk);
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        btn_up = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst", {27'd0, digit, sat}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_quiet", {27'd0, digit, sat}, 32'd0);
        end
        press(3'b001, sat_cnt, sat_edge);
        chk("fresh_press", {28'd0, digit}, 32'd1);

        // Button held through reset is re-debounced from zero.
        @(negedge clk);
        btn_up = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("held_rst", {28'd0, digit}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            chk("held_rst_lat", {28'd0, digit}, (e >= 7) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("held_rst_final", {27'd0, digit, sat}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
